usb_bulk_ep_bridge: RTL and testbench

//  User-side stage on the usb_gowin_if.user modport: bridges one bulk IN/OUT endpoint pair of the

---
 rtl/usb_gowin_pkg.sv | 16 +
 rtl/usb_gowin_if.sv | 30 +++
 rtl/usb_ep_rewind_fifo.sv | 57 +++++
 rtl/usb_bulk_ep_bridge.sv | 158 +++++++++++++++
 tb/tb_usb_bulk_ep_bridge.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_gowin_pkg.sv
// rtl/usb_gowin_pkg.sv - shared types and helpers for the Gowin USB user-side stages
package usb_gowin_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_ACK
    } tx_state_t;

    localparam int USB_MAX_PKT_FS = 64;

    function automatic logic [11:0] min_len(input int unsigned avail, input int unsigned max_pkt);
        return 12'((avail < max_pkt) ? avail : max_pkt);
    endfunction

endpackage

// File: rtl/usb_gowin_if.sv
// rtl/usb_gowin_if.sv - user-side signal bundle of the Gowin USB device core
interface usb_gowin_if;
    logic [3:0]  endpt;
    logic        setup;
    logic        rxact;
    logic        rxval;
    logic [7:0]  rxdat;
    logic        rxrdy;
    logic        txact;
    logic        txpop;
    logic [7:0]  txdat;
    logic        txval;
    logic        txcork;
    logic [11:0] txdat_len;
    logic        ack_received;
    logic        ack_tout;
    logic        ack_bad_packet;

    modport user (
        input  endpt, setup, rxact, rxval, rxdat, txact, txpop,
        input  ack_received, ack_tout, ack_bad_packet,
        output rxrdy, txdat, txval, txcork, txdat_len
    );

    modport core (
        output endpt, setup, rxact, rxval, rxdat, txact, txpop,
        output ack_received, ack_tout, ack_bad_packet,
        input  rxrdy, txdat, txval, txcork, txdat_len
    );
endinterface

// File: rtl/usb_ep_rewind_fifo.sv
// rtl/usb_ep_rewind_fifo.sv - byte FIFO with speculative read pointer and commit/rewind
module usb_ep_rewind_fifo #(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    input  logic        rd_en,
    input  logic        commit,
    input  logic        rewind,
    output logic [7:0]  rd_data,
    output logic        spec_empty,
    output logic [AW:0] level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_spec, rd_cmt, rd_spec_nxt;
    logic        push, pop;

    // Occupancy counts from the committed pointer so unacked bytes are never overwritten.
    assign level      = wr_ptr - rd_cmt;
    assign full       = (level == (AW+1)'(DEPTH));
    assign spec_empty = (wr_ptr == rd_spec);
    assign rd_data    = mem[rd_spec[AW-1:0]];
    assign push       = wr_en && !full;
    assign pop        = rd_en && !spec_empty;

    always_comb begin
        rd_spec_nxt = rewind ? rd_cmt : rd_spec + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_spec <= '0;
            rd_cmt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_spec <= rd_spec_nxt;
            if (commit) begin
                rd_cmt <= rd_spec_nxt;
            end
        end
    end

endmodule

// File: rtl/usb_bulk_ep_bridge.sv
// rtl/usb_bulk_ep_bridge.sv - bulk IN/OUT endpoint pair to application byte streams
module usb_bulk_ep_bridge
    import usb_gowin_pkg::*;
#(
    parameter  int EP_NUM   = 1,
    parameter  int MAX_PKT  = USB_MAX_PKT_FS,
    parameter  int RX_DEPTH = 128,
    parameter  int TX_DEPTH = 128,
    localparam int RAW      = $clog2(RX_DEPTH),
    localparam int TAW      = $clog2(TX_DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    usb_gowin_if.user      usb,
    output logic [7:0]     rx_data_o,
    output logic           rx_valid_o,
    input  logic           rx_ready_i,
    input  logic [7:0]     tx_data_i,
    input  logic           tx_valid_i,
    output logic           tx_ready_o,
    output logic [RAW:0]   rx_level_o,
    output logic [TAW:0]   tx_level_o,
    output logic           rx_overflow_o,
    output logic           in_retry_o
);

    logic        ep_hit, rx_wr, rx_full, rx_empty;
    logic [RAW:0] rx_free;
    logic        tx_full, tx_spec_empty, tx_run_q, tx_push, tx_pop;
    logic        txact_q, txact_rise, txact_fall;
    logic        tx_start, tx_commit, tx_rewind_err;
    logic [11:0] tx_sent;
    tx_state_t   tx_state, tx_state_nxt;

    assign ep_hit = (usb.endpt == 4'(EP_NUM)) && !usb.setup;

    assign rx_wr      = usb.rxact && usb.rxval && ep_hit;
    assign rx_valid_o = !rx_empty;
    assign rx_free    = (RAW+1)'(RX_DEPTH) - rx_level_o;

    usb_ep_rewind_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .wr_en      (rx_wr),
        .wr_data    (usb.rxdat),
        .full       (rx_full),
        .rd_en      (rx_valid_o && rx_ready_i),
        .commit     (1'b1),
        .rewind     (1'b0),
        .rd_data    (rx_data_o),
        .spec_empty (rx_empty),
        .level      (rx_level_o)
    );

    // tx_run_q holds tx_ready_o low for the first cycle after reset release.
    assign tx_ready_o = tx_run_q && !tx_full;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign tx_pop     = (tx_state == TX_SEND) && usb.txpop && !tx_spec_empty
                        && (tx_sent < usb.txdat_len);

    usb_ep_rewind_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .wr_en      (tx_push),
        .wr_data    (tx_data_i),
        .full       (tx_full),
        .rd_en      (tx_pop),
        .commit     (tx_commit),
        .rewind     (tx_start || tx_rewind_err),
        .rd_data    (usb.txdat),
        .spec_empty (tx_spec_empty),
        .level      (tx_level_o)
    );

    assign txact_rise = usb.txact && !txact_q;
    assign txact_fall = !usb.txact && txact_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    // An ack arriving with the txact fall is resolved without visiting TX_WAIT_ACK.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_start      = 1'b0;
        tx_commit     = 1'b0;
        tx_rewind_err = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (txact_rise && ep_hit && (tx_level_o != '0)) begin
                    tx_start     = 1'b1;
                    tx_state_nxt = TX_SEND;
                end
            end
            TX_SEND, TX_WAIT_ACK: begin
                if (tx_state == TX_WAIT_ACK || txact_fall) begin
                    if (usb.ack_received) begin
                        tx_commit    = 1'b1;
                        tx_state_nxt = TX_IDLE;
                    end else if (usb.ack_tout || usb.ack_bad_packet) begin
                        tx_rewind_err = 1'b1;
                        tx_state_nxt  = TX_IDLE;
                    end else begin
                        tx_state_nxt = TX_WAIT_ACK;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        usb.txcork = 1'b1;
        usb.txval  = 1'b0;
        unique case (tx_state)
            TX_IDLE:     usb.txcork = (tx_level_o == '0);
            TX_SEND: begin
                usb.txcork = 1'b0;
                usb.txval  = 1'b1;
            end
            default: begin
                usb.txcork = 1'b1;
                usb.txval  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            txact_q       <= 1'b0;
            tx_run_q      <= 1'b0;
            tx_sent       <= '0;
            usb.txdat_len <= '0;
            usb.rxrdy     <= 1'b0;
            rx_overflow_o <= 1'b0;
            in_retry_o    <= 1'b0;
        end else begin
            txact_q    <= usb.txact;
            tx_run_q   <= 1'b1;
            in_retry_o <= tx_rewind_err;
            usb.rxrdy  <= (rx_free >= (RAW+1)'(MAX_PKT));
            if (rx_wr && rx_full) begin
                rx_overflow_o <= 1'b1;
            end
            if (tx_start) begin
                usb.txdat_len <= min_len(32'(tx_level_o), $unsigned(MAX_PKT));
                tx_sent       <= '0;
            end else if (tx_pop) begin
                tx_sent <= tx_sent + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_bulk_ep_bridge.sv
// tb/tb_usb_bulk_ep_bridge.sv - self-checking bench for usb_bulk_ep_bridge
module tb_usb_bulk_ep_bridge;

    localparam int RXD = 128;
    localparam int TXD = 128;
    localparam int MP  = 64;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_level_o;
    logic [7:0] tx_level_o;
    logic       rx_overflow_o;
    logic       in_retry_o;

    usb_gowin_if usb();

    usb_bulk_ep_bridge #(
        .EP_NUM(1), .MAX_PKT(MP), .RX_DEPTH(RXD), .TX_DEPTH(TXD)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .usb           (usb),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_level_o    (rx_level_o),
        .tx_level_o    (tx_level_o),
        .rx_overflow_o (rx_overflow_o),
        .in_retry_o    (in_retry_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_got  = 0;
    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    bit exp_ovf = 0;
    bit tx_run  = 0;
    bit started = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: rx_q is the OUT byte stream, tx_q the committed IN bytes.
    task automatic step();
        bit rst, hit, acc;
        int pre;
        rst = (rst_ni !== 1'b1);
        if (started && !rst) begin
            hit = usb.rxact && usb.rxval && (usb.endpt == 4'd1) && !usb.setup;
            pre = rx_q.size();
            check("rx_valid", 32'(rx_valid_o), 32'(pre > 0));
            if (pre > 0 && rx_ready_i) begin
                check("rx_data", 32'(rx_data_o), 32'(rx_q[0]));
                void'(rx_q.pop_front());
                rx_got++;
            end
            if (hit) begin
                if (pre < RXD) rx_q.push_back(usb.rxdat);
                else           exp_ovf = 1;
            end
            acc = tx_run && (tx_q.size() < TXD);
            if (tx_valid_i) begin
                check("tx_ready", 32'(tx_ready_o), 32'(acc));
                if (acc) tx_q.push_back(tx_data_i);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            exp_ovf = 0;
            tx_run  = 0;
            started = 1;
        end else begin
            tx_run = 1;
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            tx_data_i  = 8'($urandom);
            tx_valid_i = 1'b1;
            step();
        end
        tx_valid_i = 1'b0;
    endtask

    task automatic out_pkt(input int n);
        usb.endpt = 4'd1;
        usb.rxact = 1'b1;
        usb.rxval = 1'b1;
        for (int i = 0; i < n; i++) begin
            usb.rxdat = 8'($urandom);
            step();
        end
        usb.rxact = 1'b0;
        usb.rxval = 1'b0;
    endtask

    task automatic set_ack(input int ack);
        usb.ack_received   = (ack == 0) || (ack == 3);
        usb.ack_tout       = (ack == 1) || (ack == 3);
        usb.ack_bad_packet = (ack == 2);
    endtask

    // ack: 0 received, 1 timeout, 2 bad packet, 3 received+timeout; -1 none
    task automatic in_txn(input int npops, input int ack, input bit at_fall);
        int len, used;
        bit err;
        len  = (tx_q.size() < MP) ? tx_q.size() : MP;
        used = (npops < len) ? npops : len;
        err  = (ack == 1) || (ack == 2);
        usb.endpt = 4'd1;
        usb.txact = 1'b1;
        step();
        check("in_txval", 32'(usb.txval), 32'd1);
        check("in_cork", 32'(usb.txcork), 32'd0);
        check("in_len", 32'(usb.txdat_len), 32'(len));
        usb.txpop = 1'b1;
        for (int i = 0; i < npops; i++) begin
            if (i < len) check("in_txdat", 32'(usb.txdat), 32'(tx_q[i]));
            step();
        end
        usb.txpop = 1'b0;
        usb.txact = 1'b0;
        if (!at_fall) begin
            step();
            check("wait_cork", 32'(usb.txcork), 32'd1);
            check("wait_txval", 32'(usb.txval), 32'd0);
        end
        set_ack(ack);
        step();
        set_ack(-1);
        check("in_retry", 32'(in_retry_o), 32'(err));
        if (!err) begin
            for (int i = 0; i < used; i++) void'(tx_q.pop_front());
        end
        check("tx_level", 32'(tx_level_o), 32'(tx_q.size()));
        check("idle_cork", 32'(usb.txcork), 32'(tx_q.size() == 0));
        step();
        check("retry_end", 32'(in_retry_o), 32'd0);
    endtask

    task automatic reset_checks();
        check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
        check("rst_rxrdy", 32'(usb.rxrdy), 32'd0);
        check("rst_txcork", 32'(usb.txcork), 32'd1);
        check("rst_txval", 32'(usb.txval), 32'd0);
        check("rst_txdat_len", 32'(usb.txdat_len), 32'd0);
        check("rst_overflow", 32'(rx_overflow_o), 32'd0);
        check("rst_retry", 32'(in_retry_o), 32'd0);
        check("rst_rx_level", 32'(rx_level_o), 32'd0);
        check("rst_tx_level", 32'(tx_level_o), 32'd0);
    endtask

    initial begin
        rst_ni     = 1'b0;
        rx_ready_i = 1'b0;
        tx_data_i  = 8'd0;
        tx_valid_i = 1'b0;
        usb.endpt  = 4'd1;
        usb.setup  = 1'b0;
        usb.rxact  = 1'b0;
        usb.rxval  = 1'b0;
        usb.rxdat  = 8'd0;
        usb.txact  = 1'b0;
        usb.txpop  = 1'b0;
        set_ack(-1);

        step();
        step();
        reset_checks();
        rst_ni = 1'b1;
        step();
        check("run_tx_ready", 32'(tx_ready_o), 32'd1);
        check("run_rxrdy", 32'(usb.rxrdy), 32'd1);

        // OUT 0x00..0x3F with the application always ready
        rx_ready_i = 1'b1;
        usb.rxact  = 1'b1;
        usb.rxval  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            usb.rxdat = 8'(i);
            step();
        end
        usb.rxact = 1'b0;
        usb.rxval = 1'b0;
        repeat (3) step();
        check("t1_rx_count", 32'(rx_got), 32'd64);
        check("t1_rx_level", 32'(rx_level_o), 32'd0);
        check("t1_overflow", 32'(rx_overflow_o), 32'd0);

        // Random OUT traffic: mixed endpoints, setup, valid and backpressure
        usb.rxact = 1'b1;
        for (int i = 0; i < 300; i++) begin
            usb.rxval  = 1'($urandom);
            usb.rxdat  = 8'($urandom);
            usb.endpt  = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1;
            usb.setup  = ($urandom_range(0, 7) == 0);
            rx_ready_i = 1'($urandom);
            step();
        end
        usb.rxact  = 1'b0;
        usb.setup  = 1'b0;
        usb.endpt  = 4'd1;
        rx_ready_i = 1'b1;
        repeat (140) step();
        check("rand_rx_level", 32'(rx_level_o), 32'(rx_q.size()));
        check("rand_overflow", 32'(rx_overflow_o), 32'(exp_ovf));

        // Two full packets with no reader, then one forced byte
        rx_ready_i = 1'b0;
        out_pkt(64);
        step();
        check("t2_rxrdy_half", 32'(usb.rxrdy), 32'd1);
        out_pkt(64);
        step();
        check("t2_rxrdy_full", 32'(usb.rxrdy), 32'd0);
        check("t2_rx_level", 32'(rx_level_o), 32'd128);
        out_pkt(1);
        check("t2_overflow", 32'(rx_overflow_o), 32'd1);
        check("t2_level_kept", 32'(rx_level_o), 32'd128);
        rx_ready_i = 1'b1;
        repeat (130) step();
        check("t2_drain", 32'(rx_level_o), 32'd0);
        check("t2_rxrdy_back", 32'(usb.rxrdy), 32'd1);

        // 100 bytes in two packets, extra pops beyond the length ignored
        load(100);
        check("t3_level100", 32'(tx_level_o), 32'd100);
        in_txn(67, 0, 1'b0);
        in_txn(36, 0, 1'b0);

        // Timeout rewind and resend; ack resolved on the txact fall
        load(64);
        in_txn(64, 1, 1'b0);
        in_txn(64, 0, 1'b1);
        load(40);
        in_txn(40, 2, 1'b1);
        in_txn(20, 3, 1'b0);
        in_txn(20, 0, 1'b0);

        // Empty cork, foreign endpoint, full TX FIFO
        check("t5_empty_cork", 32'(usb.txcork), 32'd1);
        load(5);
        usb.endpt = 4'd2;
        usb.txact = 1'b1;
        step();
        check("t5_ep2_txval", 32'(usb.txval), 32'd0);
        check("t5_ep2_cork", 32'(usb.txcork), 32'd0);
        usb.txact = 1'b0;
        usb.endpt = 4'd1;
        step();
        load(123);
        check("t5_full_level", 32'(tx_level_o), 32'd128);
        tx_valid_i = 1'b1;
        repeat (3) step();
        tx_valid_i = 1'b0;
        check("t5_no_ready", 32'(tx_ready_o), 32'd0);
        in_txn(64, 0, 1'b0);
        check("t5_ready_back", 32'(tx_ready_o), 32'd1);

        // Reset in the middle of an IN packet
        out_pkt(7);
        usb.txact = 1'b1;
        step();
        usb.txpop = 1'b1;
        repeat (10) step();
        check("t6_sending", 32'(usb.txval), 32'd1);
        rst_ni    = 1'b0;
        usb.txpop = 1'b0;
        usb.txact = 1'b0;
        step();
        reset_checks();
        rst_ni = 1'b1;
        step();
        check("t6_tx_ready", 32'(tx_ready_o), 32'd1);
        check("t6_txval", 32'(usb.txval), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
